// File: rtl/lc3_ctrl_pkg.sv
// Shared constants and state type for the LC3 control sequencer.
// Opcodes, EXT sub-codes, ALU codes and STAGE encodings.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_EXT = 4'b1101;

  localparam logic [2:0] SUB_MUL  = 3'b000;
  localparam logic [2:0] SUB_MULI = 3'b100;
  localparam logic [2:0] SUB_SL   = 3'b010;
  localparam logic [2:0] SUB_SR   = 3'b001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SL  = 4'b0110;
  localparam logic [3:0] ALU_SR  = 4'b0111;

  localparam logic [1:0] STG_FETCH     = 2'b00;
  localparam logic [1:0] STG_DECODE    = 2'b01;
  localparam logic [1:0] STG_EXECUTE   = 2'b10;
  localparam logic [1:0] STG_WRITEBACK = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

endpackage

// File: rtl/lc3_op_decode.sv
// Combinational instruction decode for the LC3 sequencer.
// Only sampled into registers by the FSM at the end of DECODE.
module lc3_op_decode
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] instruction,
  output logic [3:0]  alu_ctl,
  output logic        is_imm,
  output logic        legal,
  output logic        is_mul
);

  logic [3:0] op;
  logic [2:0] sub;
  logic       unused_bits;

  assign op  = instruction[15:12];
  assign sub = instruction[5:3];
  assign unused_bits = ^{instruction[11:6], instruction[2:0]};

  always_comb begin
    alu_ctl = '0;
    is_imm  = 1'b0;
    legal   = 1'b0;
    is_mul  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        alu_ctl = ALU_ADD;
        is_imm  = instruction[5];
        legal   = 1'b1;
      end
      (op == OP_AND): begin
        alu_ctl = ALU_AND;
        is_imm  = instruction[5];
        legal   = 1'b1;
      end
      (op == OP_NOT): begin
        alu_ctl = ALU_NOT;
        legal   = 1'b1;
      end
      (op == OP_EXT && sub == SUB_MUL): begin
        alu_ctl = ALU_MUL;
        legal   = 1'b1;
        is_mul  = 1'b1;
      end
      (op == OP_EXT && sub == SUB_MULI): begin
        alu_ctl = ALU_MUL;
        is_imm  = 1'b1;
        legal   = 1'b1;
        is_mul  = 1'b1;
      end
      (op == OP_EXT && sub == SUB_SL): begin
        alu_ctl = ALU_SL;
        legal   = 1'b1;
      end
      (op == OP_EXT && sub == SUB_SR): begin
        alu_ctl = ALU_SR;
        legal   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for LC3.
// Outputs are registered for the state being entered.
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned ALU_CTL_W   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RUN,
  input  logic [15:0]          INSTRUCTION,
  output logic [1:0]           STAGE,
  output logic                 BUSY,
  output logic                 MAR_LE,
  output logic                 MAR_CONTROL,
  output logic                 MEM_WE,
  output logic                 IR_LE,
  output logic                 PC_LE,
  output logic [1:0]           PC_CONTROL,
  output logic                 IS_IMMEDIATE,
  output logic [ALU_CTL_W-1:0] ALU_CONTROL,
  output logic                 RD_LE,
  output logic                 REG_CONTROL,
  output logic                 ILLEGAL_OP
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LATENCY);
  localparam logic [3:0] MUL_LAST = 4'(MUL_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       mul_op;

  logic [3:0] dec_alu;
  logic       dec_imm;
  logic       dec_legal;
  logic       dec_mul;

  lc3_op_decode u_dec (
    .instruction (INSTRUCTION),
    .alu_ctl     (dec_alu),
    .is_imm      (dec_imm),
    .legal       (dec_legal),
    .is_mul      (dec_mul)
  );

  assign MAR_CONTROL = 1'b0;
  assign MEM_WE      = 1'b0;
  assign PC_CONTROL  = 2'b00;
  assign REG_CONTROL = 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mul_op       <= 1'b0;
      STAGE        <= STG_FETCH;
      BUSY         <= 1'b0;
      MAR_LE       <= 1'b0;
      IR_LE        <= 1'b0;
      PC_LE        <= 1'b0;
      RD_LE        <= 1'b0;
      ILLEGAL_OP   <= 1'b0;
      IS_IMMEDIATE <= 1'b0;
      ALU_CONTROL  <= '0;
    end else begin
      MAR_LE     <= 1'b0;
      IR_LE      <= 1'b0;
      PC_LE      <= 1'b0;
      RD_LE      <= 1'b0;
      ILLEGAL_OP <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (RUN) begin
            state  <= S_FETCH;
            cnt    <= '0;
            STAGE  <= STG_FETCH;
            BUSY   <= 1'b1;
            MAR_LE <= 1'b1;
          end
        end
        S_FETCH: begin
          if (cnt == MEM_LAST) begin
            state <= S_DECODE;
            cnt   <= '0;
            STAGE <= STG_DECODE;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == MEM_LAST) begin
              IR_LE <= 1'b1;
              PC_LE <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          // illegal ops decode to ALU 0 / imm 0
          cnt          <= '0;
          ALU_CONTROL  <= ALU_CTL_W'(dec_alu);
          IS_IMMEDIATE <= dec_imm;
          mul_op       <= dec_mul;
          if (dec_legal) begin
            state <= S_EXECUTE;
            STAGE <= STG_EXECUTE;
          end else begin
            ILLEGAL_OP <= 1'b1;
            STAGE      <= STG_FETCH;
            if (RUN) begin
              state  <= S_FETCH;
              MAR_LE <= 1'b1;
            end else begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        S_EXECUTE: begin
          if (!mul_op || cnt == MUL_LAST) begin
            state <= S_WRITEBACK;
            cnt   <= '0;
            STAGE <= STG_WRITEBACK;
            RD_LE <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WRITEBACK: begin
          cnt   <= '0;
          STAGE <= STG_FETCH;
          if (RUN) begin
            state  <= S_FETCH;
            MAR_LE <= 1'b1;
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          STAGE <= STG_FETCH;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
